// File: rtl/bcd_digit_gen.sv
// ---------------------------------------------------------------------------
// bcd_digit_gen
//
// Converts a 32-bit unsigned binary value into eight packed BCD digits for the
// seven-segment decoder stage. The conversion is iterative double-dabble
// (shift-add-3) over 27 bits, one iteration per clock. Values above
// 99_999_999 saturate to all 9s and raise ovf_o.
//
// Ports:
//   clk_i        in   1   system clock, rising edge
//   rst_i        in   1   synchronous reset, active high
//   start_i      in   1   conversion request, sampled only in IDLE
//   value_i      in  32   unsigned binary value, sampled on the accepting edge
//   busy_o       out  1   high while state != IDLE
//   done_o       out  1   one-cycle pulse; digits valid from this cycle on
//   ovf_o        out  1   last result saturated; held with the digits
//   io_hex0_o .. io_hex7_o
//                out  7   BCD digit in [3:0], [6:4] always 0; hex0 = LSD
//   dbg_state_o  out  2   current FSM state (0 IDLE, 1 CONV, 2 DONE)
//
// Handshake: start_i is a request, not a valid/ready pair. It is consumed on
// the first rising edge where the block is IDLE and rst_i is low; while busy_o
// is high it is ignored and nothing is queued. Completion is signalled by a
// single done_o pulse.
// ---------------------------------------------------------------------------
module bcd_digit_gen (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        start_i,
  input  logic [31:0] value_i,
  output logic        busy_o,
  output logic        done_o,
  output logic        ovf_o,
  output logic [6:0]  io_hex0_o,
  output logic [6:0]  io_hex1_o,
  output logic [6:0]  io_hex2_o,
  output logic [6:0]  io_hex3_o,
  output logic [6:0]  io_hex4_o,
  output logic [6:0]  io_hex5_o,
  output logic [6:0]  io_hex6_o,
  output logic [6:0]  io_hex7_o,
  output logic [1:0]  dbg_state_o
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CONV = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [31:0] MAX_VALUE = 32'd99_999_999;
  // 99_999_999 < 2^27, so 27 shift iterations cover every in-range value.
  localparam logic [4:0]  LAST_ITER = 5'd26;
  localparam logic [31:0] ALL_NINES = 32'h9999_9999;

  state_t      state_q;
  logic [26:0] bin_q;
  logic [31:0] bcd_q;
  logic [4:0]  cnt_q;
  logic [31:0] digits_q;

  logic [31:0] bcd_adj;
  logic [31:0] bcd_next;

  // Add 3 to every nibble >= 5. A nibble <= 9 becomes at most 12, so the
  // 4-bit add never carries out.
  always_comb begin
    bcd_adj = bcd_q;
    for (int i = 0; i < 8; i++) begin
      if (bcd_q[4*i +: 4] >= 4'd5) begin
        bcd_adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
      end
    end
  end

  // Left shift of {bcd, bin}: the MSB of the binary register enters the BCD LSB.
  assign bcd_next = {bcd_adj[30:0], bin_q[26]};

  // The DONE-state result is loaded on the edge that enters DONE, so that
  // done_o and the new digits are both visible during the DONE cycle while
  // all outputs stay purely registered.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q  <= IDLE;
      bin_q    <= '0;
      bcd_q    <= '0;
      cnt_q    <= '0;
      digits_q <= '0;
      busy_o   <= 1'b0;
      done_o   <= 1'b0;
      ovf_o    <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          done_o <= 1'b0;
          if (start_i) begin
            busy_o <= 1'b1;
            if (value_i > MAX_VALUE) begin
              state_q  <= DONE;
              digits_q <= ALL_NINES;
              ovf_o    <= 1'b1;
              done_o   <= 1'b1;
            end else begin
              state_q <= CONV;
              bin_q   <= value_i[26:0];
              bcd_q   <= '0;
              cnt_q   <= '0;
            end
          end
        end

        CONV: begin
          bcd_q <= bcd_next;
          bin_q <= {bin_q[25:0], 1'b0};
          cnt_q <= cnt_q + 5'd1;
          if (cnt_q == LAST_ITER) begin
            state_q  <= DONE;
            digits_q <= bcd_next;
            ovf_o    <= 1'b0;
            done_o   <= 1'b1;
          end
        end

        DONE: begin
          state_q <= IDLE;
          busy_o  <= 1'b0;
          done_o  <= 1'b0;
        end

        default: begin
          state_q <= IDLE;
          busy_o  <= 1'b0;
          done_o  <= 1'b0;
        end
      endcase
    end
  end

  assign io_hex0_o   = {3'b000, digits_q[3:0]};
  assign io_hex1_o   = {3'b000, digits_q[7:4]};
  assign io_hex2_o   = {3'b000, digits_q[11:8]};
  assign io_hex3_o   = {3'b000, digits_q[15:12]};
  assign io_hex4_o   = {3'b000, digits_q[19:16]};
  assign io_hex5_o   = {3'b000, digits_q[23:20]};
  assign io_hex6_o   = {3'b000, digits_q[27:24]};
  assign io_hex7_o   = {3'b000, digits_q[31:28]};
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_bcd_digit_gen.sv
// ---------------------------------------------------------------------------
// tb_bcd_digit_gen
//
// Self-checking bench for bcd_digit_gen. A cycle-level reference tracks when
// a request is accepted and when done_o is due; expected digits (computed by
// decimal division) are queued at acceptance and popped when done_o appears.
// Outputs are sampled on the falling clock edge.
// ---------------------------------------------------------------------------
module tb_bcd_digit_gen;

  // ---------------- clock / reset ----------------
  logic        clk = 1'b0;
  logic        rst_i;
  logic        start_i;
  logic [31:0] value_i;
  logic        busy_o, done_o, ovf_o;
  logic [6:0]  io_hex0_o, io_hex1_o, io_hex2_o, io_hex3_o;
  logic [6:0]  io_hex4_o, io_hex5_o, io_hex6_o, io_hex7_o;
  logic [1:0]  dbg_state_o;

  always #5 clk = ~clk;

  bcd_digit_gen dut (
    .clk_i       (clk),
    .rst_i       (rst_i),
    .start_i     (start_i),
    .value_i     (value_i),
    .busy_o      (busy_o),
    .done_o      (done_o),
    .ovf_o       (ovf_o),
    .io_hex0_o   (io_hex0_o),
    .io_hex1_o   (io_hex1_o),
    .io_hex2_o   (io_hex2_o),
    .io_hex3_o   (io_hex3_o),
    .io_hex4_o   (io_hex4_o),
    .io_hex5_o   (io_hex5_o),
    .io_hex6_o   (io_hex6_o),
    .io_hex7_o   (io_hex7_o),
    .dbg_state_o (dbg_state_o)
  );

  // ---------------- checking ----------------
  int n_checks = 0;
  int n_fails  = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // {ovf, 8 BCD digits}
  logic [32:0] exp_q[$];

  function automatic logic [32:0] expect_of(input logic [31:0] v);
    logic [31:0] d;
    logic [31:0] t;
    if (v > 32'd99_999_999) return {1'b1, 32'h9999_9999};
    d = '0;
    t = v;
    for (int i = 0; i < 8; i++) begin
      d[4*i +: 4] = 4'(t % 10);
      t = t / 10;
    end
    return {1'b0, d};
  endfunction

  function automatic logic [55:0] pack_hex(input logic [31:0] d);
    logic [55:0] p;
    for (int i = 0; i < 8; i++) p[7*i +: 7] = {3'b000, d[4*i +: 4]};
    return p;
  endfunction

  // ---------------- cycle reference ----------------
  logic        chk_en    = 1'b0;
  logic        m_busy    = 1'b0;
  logic        m_done    = 1'b0;
  logic        m_pending = 1'b0;
  int          m_left    = 0;
  logic [32:0] held      = '0;

  always @(posedge clk) begin
    if (rst_i) begin
      if (m_pending) void'(exp_q.pop_back());
      m_pending = 1'b0;
      m_busy    = 1'b0;
      m_done    = 1'b0;
      m_left    = 0;
      held      = '0;
      chk_en    = 1'b1;
    end else if (!m_busy) begin
      m_done = 1'b0;
      if (start_i) begin
        logic [32:0] e;
        e = expect_of(value_i);
        exp_q.push_back(e);
        m_pending = 1'b1;
        m_busy    = 1'b1;
        m_left    = e[32] ? 0 : 27;
        m_done    = (m_left == 0);
      end
    end else if (m_done) begin
      m_busy = 1'b0;
      m_done = 1'b0;
    end else begin
      m_left--;
      m_done = (m_left == 0);
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      if (done_o) begin
        if (exp_q.size() == 0) begin
          check_eq("sb_underflow", 64'(exp_q.size()), 64'd1);
        end else begin
          held      = exp_q.pop_front();
          m_pending = 1'b0;
        end
      end
      check_eq("done", 64'(done_o), 64'(m_done));
      check_eq("busy", 64'(busy_o), 64'(m_busy));
      check_eq("digits",
               64'({io_hex7_o, io_hex6_o, io_hex5_o, io_hex4_o,
                    io_hex3_o, io_hex2_o, io_hex1_o, io_hex0_o}),
               64'(pack_hex(held[31:0])));
      check_eq("ovf", 64'(ovf_o), 64'(held[32]));
    end
  end

  // ---------------- driver tasks ----------------
  // Called at a falling edge; holds start_i for exactly one rising edge.
  task automatic drive_start(input logic [31:0] v);
    start_i = 1'b1;
    value_i = v;
    @(negedge clk);
    start_i = 1'b0;
    value_i = $urandom();
  endtask

  // Returns at a falling edge in an IDLE cycle.
  task automatic wait_idle();
    int n;
    n = 0;
    @(negedge clk);
    while ((busy_o || m_busy) && n < 60) begin
      @(negedge clk);
      n++;
    end
    if (n >= 60) check_eq("idle_timeout", 64'(n), 64'd0);
  endtask

  task automatic convert(input logic [31:0] v);
    drive_start(v);
    wait_idle();
  endtask

  // ---------------- stimulus ----------------
  initial begin
    rst_i   = 1'b1;
    start_i = 1'b0;
    value_i = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_i = 1'b0;
    @(negedge clk);

    // Ordinary and boundary values, back-to-back at full throughput.
    convert(32'd12_345_678);
    convert(32'd0);
    convert(32'd99_999_999);

    // Overflow then recovery.
    convert(32'd100_000_000);
    convert(32'hFFFF_FFFF);
    convert(32'd7);

    // Busy lockout: extra starts in cycle 5 (CONV) and cycle 28 (DONE).
    drive_start(32'd555);                 // now in cycle 1 after accept
    repeat (4) @(negedge clk);            // cycle 5
    drive_start(32'd42);                  // cycle 6
    repeat (22) @(negedge clk);           // cycle 28
    drive_start(32'd42);
    wait_idle();
    convert(32'd42);

    // Reset mid-conversion, then redo.
    drive_start(32'd87_654_321);          // cycle 1
    repeat (9) @(negedge clk);            // cycle 10
    rst_i = 1'b1;
    @(negedge clk);
    rst_i = 1'b0;
    @(negedge clk);
    convert(32'd87_654_321);

    // Random values, mostly in range, some saturating.
    for (int i = 0; i < 12; i++) begin
      if ($urandom_range(0, 3) == 0) convert($urandom_range(100_000_000, 32'hFFFF_FFFF));
      else                           convert($urandom_range(0, 99_999_999));
    end

    repeat (3) @(negedge clk);
    check_eq("sb_drained", 64'(exp_q.size()), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
